// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        DEC_BASE,
        DEC_E0,
        DEC_F0,
        DEC_E0F0
    } dec_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int         EV_W    = 10;

endpackage

// File: rtl/ps2_scan_sequencer_if.sv
// Key-event handshake between the PS/2 front end and its consumer.
interface ps2_scan_sequencer_if;
    import ps2_pkg::*;

    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (output ev_valid, output ev_code, output ev_ext, output ev_break,
                    input  ev_ready);
    modport slave  (input  ev_valid, input  ev_code, input  ev_ext, input  ev_break,
                    output ev_ready);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by an all-samples-agree glitch filter.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk25,
    input  logic clr,
    input  logic raw,
    output logic filt
);
    logic                sync1_q, sync2_q;
    logic [FILT_LEN-1:0] shift_q, shift_d;
    logic                filt_q, filt_d;

    always_comb begin
        shift_d = {shift_q[FILT_LEN-2:0], sync2_q};
        filt_d  = filt_q;
        if (&shift_q)
            filt_d = 1'b1;
        else if (~|shift_q)
            filt_d = 1'b0;
    end

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            shift_q <= '1;
            filt_q  <= 1'b1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            shift_q <= shift_d;
            filt_q  <= filt_d;
        end
    end

    assign filt = filt_q;
endmodule

// File: rtl/ps2_scan_sequencer.sv
// PS/2 frame receiver: filtered lines -> 11-bit frame FSM -> E0/F0 prefix folding -> event FIFO.
module ps2_scan_sequencer
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 25000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk25,
    input  logic                        clr,
    input  logic                        PS2C,
    input  logic                        PS2D,
    ps2_scan_sequencer_if.master        ev,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        overflow,
    output logic                        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic c_filt, d_filt, fall;
    logic c_prev_q;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_c (.clk25(clk25), .clr(clr), .raw(PS2C), .filt(c_filt));
    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_d (.clk25(clk25), .clr(clr), .raw(PS2D), .filt(d_filt));

    assign fall = c_prev_q & ~c_filt;

    frame_state_t    frame_q, frame_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      data_q, data_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            byte_ok_q, byte_ok_d;
    logic            err_parity_q, err_parity_d;
    logic            err_frame_q, err_frame_d;

    always_comb begin
        frame_d      = frame_q;
        bitcnt_d     = bitcnt_q;
        data_d       = data_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        byte_ok_d    = 1'b0;
        err_parity_d = 1'b0;
        err_frame_d  = 1'b0;
        if (fall) begin
            tmo_d = '0;
            case (frame_q)
                FR_IDLE: begin
                    if (!d_filt) begin
                        frame_d  = FR_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
                FR_DATA: begin
                    data_d[bitcnt_q] = d_filt;
                    bitcnt_d         = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7)
                        frame_d = FR_PARITY;
                end
                FR_PARITY: begin
                    par_d   = d_filt;
                    frame_d = FR_STOP;
                end
                FR_STOP: begin
                    frame_d = FR_IDLE;
                    // A bad stop bit hides any parity problem in the same frame.
                    if (!d_filt)
                        err_frame_d = 1'b1;
                    else if (^{data_q, par_q})
                        byte_ok_d = 1'b1;
                    else
                        err_parity_d = 1'b1;
                end
                default: frame_d = FR_IDLE;
            endcase
        end else if (frame_q != FR_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                frame_d     = FR_IDLE;
                err_frame_d = 1'b1;
                tmo_d       = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    dec_state_t      dec_q, dec_d;
    logic            emit_q, emit_d;
    logic [EV_W-1:0] emit_ev_q, emit_ev_d;

    always_comb begin
        dec_d     = dec_q;
        emit_d    = 1'b0;
        emit_ev_d = emit_ev_q;
        if (byte_ok_q) begin
            case (dec_q)
                DEC_BASE: begin
                    if (data_q == PS2_EXT)
                        dec_d = DEC_E0;
                    else if (data_q == PS2_BRK)
                        dec_d = DEC_F0;
                    else begin
                        emit_d    = 1'b1;
                        emit_ev_d = {1'b0, 1'b0, data_q};
                    end
                end
                DEC_E0: begin
                    if (data_q == PS2_BRK)
                        dec_d = DEC_E0F0;
                    else if (data_q != PS2_EXT) begin
                        emit_d    = 1'b1;
                        emit_ev_d = {1'b1, 1'b0, data_q};
                        dec_d     = DEC_BASE;
                    end
                end
                DEC_F0: begin
                    emit_d    = 1'b1;
                    emit_ev_d = {1'b0, 1'b1, data_q};
                    dec_d     = DEC_BASE;
                end
                default: begin
                    emit_d    = 1'b1;
                    emit_ev_d = {1'b1, 1'b1, data_q};
                    dec_d     = DEC_BASE;
                end
            endcase
        end
    end

    logic [EV_W-1:0] mem_q [FIFO_DEPTH];
    logic [EV_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            full, pop, push;

    assign full = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop  = ev.ev_valid & ev.ev_ready;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign push = emit_q & (~full | pop);

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (emit_q & full & ~pop);
        if (push) begin
            mem_d[wr_ptr_q] = emit_ev_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk25 or posedge clr) begin
            if (clr)
                mem_q[gi] <= '0;
            else
                mem_q[gi] <= mem_d[gi];
        end
    end

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            c_prev_q     <= 1'b1;
            frame_q      <= FR_IDLE;
            bitcnt_q     <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_ok_q    <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            dec_q        <= DEC_BASE;
            emit_q       <= 1'b0;
            emit_ev_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            c_prev_q     <= c_filt;
            frame_q      <= frame_d;
            bitcnt_q     <= bitcnt_d;
            data_q       <= data_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_ok_q    <= byte_ok_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
            dec_q        <= dec_d;
            emit_q       <= emit_d;
            emit_ev_q    <= emit_ev_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ev.ev_valid = (count_q != '0);
    assign {ev.ev_ext, ev.ev_break, ev.ev_code} = mem_q[rd_ptr_q];
    assign err_parity  = err_parity_q;
    assign err_frame   = err_frame_q;
    assign overflow    = overflow_q;
    assign busy        = (frame_q != FR_IDLE);
endmodule
